sys_mem_slave: RTL and testbench

//  Word-addressed SRAM target on the system bus driven by the axi_slave bridge (sys_* side).

---
 rtl/sys_mem_slave.sv | 134 +++++++++++++
 tb/tb_sys_mem_slave.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sys_mem_slave.sv
// Word-addressed scratch SRAM target for the sys_* bus, one access at a time.
// Optional range checking against BASE_ADDR/DEPTH when SYS_MEM_BOUNDS_EN is defined.
module sys_mem_slave #(
    parameter int              DW          = 64,
    parameter int              AW          = 32,
    parameter int              SW          = DW / 8,
    parameter int              DEPTH       = 1024,
    parameter int              WAIT_CYCLES = 0,
    parameter logic [AW-1:0]   BASE_ADDR   = '0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] sys_addr,
    input  logic [DW-1:0] sys_wdata,
    input  logic [SW-1:0] sys_sel,
    input  logic          sys_wen,
    input  logic          sys_ren,
    output logic [DW-1:0] sys_rdata,
    output logic          sys_ack,
    output logic          sys_err
);

    localparam int LSB = $clog2(SW);
    localparam int IW  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t state, state_nx;

    logic [7:0]    cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] sel_q;
    logic          wr_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic [DW-1:0] mem [DEPTH];

    logic          in_idle;
    logic          req;
    logic          enter_ack;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;
    logic [SW-1:0] sel_s;
    logic          wr_s;
    logic [IW-1:0] idx;
    logic          oob;

    assign in_idle = (state == S_IDLE);
    assign req     = sys_wen | sys_ren;

    // With zero wait states the commit edge is the sample edge itself,
    // so the access source is the live bus in IDLE and the latch otherwise.
    assign addr_s  = in_idle ? sys_addr  : addr_q;
    assign wdata_s = in_idle ? sys_wdata : wdata_q;
    assign sel_s   = in_idle ? sys_sel   : sel_q;
    assign wr_s    = in_idle ? sys_wen   : wr_q;

`ifdef SYS_MEM_BOUNDS_EN
    logic [AW-1:0] off;
    logic          unused_off;
    assign off        = addr_s - BASE_ADDR;
    assign oob        = (addr_s < BASE_ADDR) || (off[AW-1:LSB+IW] != '0);
    assign idx        = off[LSB +: IW];
    assign unused_off = ^off[LSB-1:0];
`else
    logic unused_addr;
    assign oob         = 1'b0;
    assign idx         = addr_s[LSB +: IW];
    assign unused_addr = ^{addr_s[LSB-1:0], addr_s[AW-1:LSB+IW], BASE_ADDR};
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nx = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 8'd0) begin
                    state_nx = S_ACK;
                end
            end
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign enter_ack = (state != S_ACK) && (state_nx == S_ACK);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= 8'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (in_idle && req) begin
                addr_q  <= sys_addr;
                wdata_q <= sys_wdata;
                sel_q   <= sys_sel;
                wr_q    <= sys_wen;
                cnt     <= 8'(WAIT_CYCLES - 1);
            end else if (state == S_WAIT && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            rdata_q <= (enter_ack && !wr_s && !oob) ? mem[idx] : '0;
            err_q   <= enter_ack && oob;
        end
    end

    // Storage has no reset; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (rstn && enter_ack && wr_s && !oob) begin
            for (int i = 0; i < SW; i++) begin
                if (sel_s[i]) begin
                    mem[idx][i*8 +: 8] <= wdata_s[i*8 +: 8];
                end
            end
        end
    end

    assign sys_ack   = (state == S_ACK);
    assign sys_rdata = rdata_q;
    assign sys_err   = err_q;

endmodule

// File: tb/tb_sys_mem_slave.sv
// Directed bench for sys_mem_slave: three instances with 0, 3 and 4 wait states.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_sys_mem_slave;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] addr  [3];
    logic [63:0] wdata [3];
    logic [7:0]  sel   [3];
    logic        wen   [3];
    logic        ren   [3];
    logic [63:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sys_mem_slave #(
            .WAIT_CYCLES((g == 0) ? 0 : g + 2)
        ) u_dut (
            .clk       (clk),
            .rstn      (rstn),
            .sys_addr  (addr[g]),
            .sys_wdata (wdata[g]),
            .sys_sel   (sel[g]),
            .sys_wen   (wen[g]),
            .sys_ren   (ren[g]),
            .sys_rdata (rdata[g]),
            .sys_ack   (ack[g]),
            .sys_err   (err[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one access on unit u, hold it until ack, then drop it.
    task automatic acc(input int u, input logic w, input logic r,
                       input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] s, output logic [63:0] rd,
                       output logic e, output int lat);
        addr[u]  = a;
        wdata[u] = d;
        sel[u]   = s;
        wen[u]   = w;
        ren[u]   = r;
        lat      = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!ack[u] && lat < 40);
        chk($sformatf("ack_seen u%0d", u), 64'(ack[u]), 64'd1);
        rd     = rdata[u];
        e      = err[u];
        wen[u] = 1'b0;
        ren[u] = 1'b0;
        @(negedge clk);
        chk($sformatf("ack_1cyc u%0d", u), 64'(ack[u]), 64'd0);
        chk($sformatf("rdata_idle u%0d", u), rdata[u], 64'd0);
    endtask

    logic [63:0] rd;
    logic        e;
    int          lat;

    initial begin
        rstn = 1'b0;
        for (int u = 0; u < 3; u++) begin
            addr[u]  = '0;
            wdata[u] = '0;
            sel[u]   = '0;
            wen[u]   = 1'b0;
            ren[u]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_ack u%0d", u), 64'(ack[u]), 64'd0);
            chk($sformatf("rst_err u%0d", u), 64'(err[u]), 64'd0);
            chk($sformatf("rst_rdata u%0d", u), rdata[u], 64'd0);
        end
        rstn = 1'b1;
        @(negedge clk);

        // basic write/read, zero wait states
        acc(0, 1, 0, 32'h1000, 64'hDEADBEEF12345678, 8'hFF, rd, e, lat);
        chk("t1_wr_lat", 64'(lat), 64'd1);
        chk("t1_wr_rdata", rd, 64'd0);
        chk("t1_wr_err", 64'(e), 64'd0);
        acc(0, 0, 1, 32'h1000, 64'd0, 8'h00, rd, e, lat);
        chk("t1_rd_lat", 64'(lat), 64'd1);
        chk("t1_rd_data", rd, 64'hDEADBEEF12345678);
        chk("t1_rd_err", 64'(e), 64'd0);

        // byte mask
        acc(0, 1, 0, 32'h1000, 64'd0, 8'hFF, rd, e, lat);
        acc(0, 1, 0, 32'h1000, 64'hFFFFFFFFFFFFFFFF, 8'h0F, rd, e, lat);
        acc(0, 0, 1, 32'h1000, 64'd0, 8'h00, rd, e, lat);
        chk("t2_mask", rd, 64'h00000000FFFFFFFF);
        acc(0, 1, 0, 32'h1000, 64'h1122334455667788, 8'h00, rd, e, lat);
        chk("t2_sel0_lat", 64'(lat), 64'd1);
        acc(0, 0, 1, 32'h1000, 64'd0, 8'h00, rd, e, lat);
        chk("t2_sel0_keep", rd, 64'h00000000FFFFFFFF);

        // wen and ren together act as a write
        acc(0, 1, 1, 32'h2000, 64'hA5A5A5A5A5A5A5A5, 8'hFF, rd, e, lat);
        chk("t4_both_rdata", rd, 64'd0);
        acc(0, 0, 1, 32'h2000, 64'd0, 8'h00, rd, e, lat);
`ifdef SYS_MEM_BOUNDS_EN
        chk("t4_rd_err", 64'(e), 64'd1);
        chk("t4_rd_data", rd, 64'd0);
`else
        chk("t4_rd_data", rd, 64'hA5A5A5A5A5A5A5A5);
`endif

        // bounds / aliasing
        acc(0, 1, 0, 32'h0, 64'h0123456789ABCDEF, 8'hFF, rd, e, lat);
        acc(0, 0, 1, 32'h2000, 64'd0, 8'h00, rd, e, lat);
`ifdef SYS_MEM_BOUNDS_EN
        chk("t5_rd_err", 64'(e), 64'd1);
        chk("t5_rd_data", rd, 64'd0);
        acc(0, 1, 0, 32'h2000, 64'hCAFEF00DCAFEF00D, 8'hFF, rd, e, lat);
        chk("t5_wr_err", 64'(e), 64'd1);
        chk("t5_wr_lat", 64'(lat), 64'd1);
        acc(0, 0, 1, 32'h0, 64'd0, 8'h00, rd, e, lat);
        chk("t5_nochange", rd, 64'h0123456789ABCDEF);
`else
        chk("t5_alias_rd", rd, 64'h0123456789ABCDEF);
        acc(0, 1, 0, 32'h2000, 64'hCAFEF00DCAFEF00D, 8'hFF, rd, e, lat);
        chk("t5_wr_err", 64'(e), 64'd0);
        acc(0, 0, 1, 32'h0, 64'd0, 8'h00, rd, e, lat);
        chk("t5_alias_wr", rd, 64'hCAFEF00DCAFEF00D);
`endif

        // three wait states, read held high continuously
        acc(1, 1, 0, 32'h100, 64'h1111111111111111, 8'hFF, rd, e, lat);
        chk("t3_wr_lat", 64'(lat), 64'd4);
        acc(1, 1, 0, 32'h108, 64'h2222222222222222, 8'hFF, rd, e, lat);
        addr[1] = 32'h100;
        ren[1]  = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) addr[1] = 32'h108;
            chk($sformatf("t3_ack k%0d", k), 64'(ack[1]),
                64'((k % 5) == 4));
            if (k == 4)
                chk("t3_latched", rdata[1], 64'h1111111111111111);
            if (k == 9)
                chk("t3_second", rdata[1], 64'h2222222222222222);
        end
        ren[1] = 1'b0;
        repeat (6) @(negedge clk);

        // reset in the middle of a waited write
        acc(2, 1, 0, 32'h1008, 64'h5555AAAA5555AAAA, 8'hFF, rd, e, lat);
        chk("t6_wr_lat", 64'(lat), 64'd5);
        addr[2]  = 32'h1008;
        wdata[2] = 64'h0F0F0F0F0F0F0F0F;
        sel[2]   = 8'hFF;
        wen[2]   = 1'b1;
        repeat (2) @(negedge clk);
        rstn   = 1'b0;
        wen[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_ack", 64'(ack[2]), 64'd0);
        chk("t6_rst_rdata", rdata[2], 64'd0);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t6_noack k%0d", k), 64'(ack[2]), 64'd0);
        end
        acc(2, 0, 1, 32'h1008, 64'd0, 8'h00, rd, e, lat);
        chk("t6_idle_lat", 64'(lat), 64'd5);
        chk("t6_kept", rd, 64'h5555AAAA5555AAAA);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
